ctrl_sel_fsm: RTL and testbench
===============================

// Module: ctrl_sel_fsm
// PURPOSE
//  Registered, parametrised successor to the 4-input combinational select/reset controller.
//  Arbitrates N request lines into a binary select code, sel_valid and a 1-cycle clr pulse
//  on every selection change. Drives datapath mux selects and counter clears.
//  Adds a minimum hold time, fixed-priority or round-robin mode, and early release.
// PARAMETERS
//  N     4  number of request channels (>=2)
//  SW    $clog2(N)  select width (derived; do not override)
//  HOLD  4  minimum grant length in cycles with sel_valid=1 (>=1)
//  MODE  0  0 = fixed priority (bit 0 highest); 1 = round-robin starting after current sel
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   asynchronous active-low reset
//  req        in   N   request lines, level-sensitive, sampled on clk
//  sel        out  SW  registered select code of the granted channel
//  sel_valid  out  1   sel is granted and stable
//  clr        out  1   1-cycle pulse, one cycle before each new grant becomes valid
//  idle       out  1   FSM in IDLE (no grant)
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, sel=0, sel_valid=0, clr=0, idle=1, hold_cnt=0.
//  - Every output is a register. No output has a combinational path from req.
//  - States: IDLE, SWITCH, GRANT.
//  - Winner function pick(req, base):
//    - MODE 0: lowest set index in req; base is ignored.
//    - MODE 1: first set index scanning base+1, base+2, ... and wrapping to base.
//    - The function reports none when req == 0.
//  - IDLE: if req != 0, then sel <= pick(req, sel), clr <= 1, go to SWITCH.
//    Otherwise stay; sel keeps its value.
//  - SWITCH: lasts exactly one cycle. clr=1, sel_valid=0. Next: GRANT, clr <= 0, sel_valid <= 1, hold_cnt <= 0.
//  - GRANT: hold_cnt increments each cycle, saturating at HOLD-1. The FSM re-arbitrates when:
//    (a) req[sel]==0 (early release, regardless of hold_cnt), or
//    (b) hold_cnt==HOLD-1.
//  - Re-arbitration result w = pick(req, sel):
//    - none: go to IDLE, sel_valid <= 0, sel held.
//    - w == sel: stay in GRANT, hold_cnt <= 0, no clr pulse.
//    - otherwise: sel <= w, sel_valid <= 0, clr <= 1, go to SWITCH.
//  - Latency: req rises in IDLE at edge k. clr=1 after edge k+1. sel_valid=1 after edge k+2.
//  - A grant with continuous req[sel] gives at least HOLD cycles of sel_valid=1.
//  - Switch gap: sel_valid is low for exactly 1 cycle (the SWITCH state) between grants.
//  - Requests that appear or drop during SWITCH are ignored until the next GRANT decision.
//  - Simultaneous requests are resolved only by the pick() rule. Round-robin wrap goes N-1 -> 0.
//  - Reset asserted mid-SWITCH or mid-GRANT aborts with no clr pulse. Restart begins from IDLE.
//  - Non-power-of-2 N: sel never takes a value >= N.
// STRUCTURE
//  - ctrl_pkg: state enum (IDLE=2'd0, SWITCH=2'd1, GRANT=2'd2) and the MODE_FP/MODE_RR constants.
//  - Sub-module ctrl_prio_pick: combinational rotating-priority picker
//    (req, base, mode -> winner, found). Instantiated once.
//  - Top level: FSM, hold counter ($clog2(HOLD+1) bits), output registers.
// TESTING
//  1. Reset: assert rst_n=0 mid-GRANT with sel=2.
//     -> same instant: sel=0, sel_valid=0, clr=0, idle=1.
//  2. MODE0, N=4, HOLD=4: req=4'b0001 held.
//     -> clr=1 for 1 cycle, then sel=0 with sel_valid=1 continuously and no further clr.
//  3. MODE0: req=4'b1010 held, then req becomes 4'b1011 during GRANT.
//     -> sel=1. At hold expiry: clr pulse, sel=0.
//  4. MODE1: req=4'b1111 held.
//     -> sel sequence 0,1,2,3,0. Each grant has exactly 4 valid cycles, each preceded by 1 clr cycle.
//  5. Early release: grant ch2, then req->0 at hold_cnt=1.
//     -> next cycle idle=1, sel_valid=0, sel stays 2.
//  6. MODE0 sweep req = 0..15, each held 10 cycles, reset between steps.
//     -> sel = lowest set bit. For req=0: idle stays 1 and clr is never asserted.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared types and constants for the select/reset controller.
//   state_t  : FSM state encoding (IDLE, SWITCH, GRANT)
//   MODE_FP  : fixed-priority arbitration, channel 0 highest
//   MODE_RR  : round-robin arbitration, scanning after the current select
// ---------------------------------------------------------------------------
package ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWITCH = 2'd1,
    GRANT  = 2'd2
  } state_t;

  localparam int MODE_FP = 0;
  localparam int MODE_RR = 1;

endpackage

// File: rtl/ctrl_prio_pick.sv
// ---------------------------------------------------------------------------
// ctrl_prio_pick
// Combinational rotating-priority picker.
// Ports:
//   req    in   N   request lines
//   base   in   SW  current select; round-robin scanning starts at base+1
//   mode   in   1   0 = fixed priority (index 0 highest), 1 = round-robin
//   winner out  SW  index of the winning request (0 when none)
//   found  out  1   at least one request is set
// ---------------------------------------------------------------------------
module ctrl_prio_pick #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] base,
  input  logic          mode,
  output logic [SW-1:0] winner,
  output logic          found
);

  // Offsets are scanned from farthest to nearest so the nearest set request
  // is the last one written and therefore wins, avoiding an early exit.
  // Indices stay below 2N, so a single conditional subtract replaces modulo.
  always_comb begin
    int start_idx;
    int idx;
    winner    = '0;
    found     = 1'b0;
    start_idx = mode ? int'(base) + 1 : 0;
    if (start_idx >= N) start_idx = start_idx - N;
    for (int off = N - 1; off >= 0; off--) begin
      idx = start_idx + off;
      if (idx >= N) idx = idx - N;
      if (req[idx[SW-1:0]]) begin
        winner = SW'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ctrl_sel_fsm.sv
// ---------------------------------------------------------------------------
// ctrl_sel_fsm
// Registered select/reset controller. Arbitrates N request lines into a
// binary select code with a minimum hold time and a one-cycle clear pulse
// ahead of every new grant.
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   req        in   N   level-sensitive request lines
//   sel        out  SW  registered select of the granted channel
//   sel_valid  out  1   sel is granted and stable
//   clr        out  1   one-cycle pulse before each new grant becomes valid
//   idle       out  1   no grant in progress
// ---------------------------------------------------------------------------
module ctrl_sel_fsm
  import ctrl_pkg::*;
#(
  parameter int N    = 4,
  parameter int SW   = $clog2(N),
  parameter int HOLD = 4,
  parameter int MODE = MODE_FP
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [SW-1:0] sel,
  output logic          sel_valid,
  output logic          clr,
  output logic          idle
);

  localparam int            HW       = $clog2(HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD - 1);
  localparam logic          RR_EN    = (MODE == MODE_RR);

  state_t        state_q, state_d;
  logic [HW-1:0] hold_cnt, hold_d;
  logic [SW-1:0] sel_d;
  logic          sel_valid_d, clr_d, idle_d;
  logic [SW-1:0] winner;
  logic          found;

  // The picker always scans relative to the registered select, so the
  // round-robin pointer is simply the last granted channel.
  ctrl_prio_pick #(
    .N  (N),
    .SW (SW)
  ) u_pick (
    .req    (req),
    .base   (sel),
    .mode   (RR_EN),
    .winner (winner),
    .found  (found)
  );

  // Next-state and next-output logic. Every output is registered, so the
  // values computed here are what the outputs show after the next edge.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel;
    sel_valid_d = sel_valid;
    clr_d       = 1'b0;
    hold_d      = hold_cnt;
    case (state_q)
      IDLE: begin
        sel_valid_d = 1'b0;
        if (found) begin
          sel_d   = winner;
          clr_d   = 1'b1;
          state_d = SWITCH;
        end
      end
      SWITCH: begin
        state_d     = GRANT;
        sel_valid_d = 1'b1;
        hold_d      = '0;
      end
      GRANT: begin
        if (hold_cnt != HOLD_MAX) hold_d = hold_cnt + HW'(1);
        // Early release overrides the hold counter; otherwise the grant is
        // re-arbitrated once it has shown HOLD valid cycles.
        if (!req[sel] || (hold_cnt == HOLD_MAX)) begin
          if (!found) begin
            state_d     = IDLE;
            sel_valid_d = 1'b0;
          end else if (winner == sel) begin
            hold_d = '0;
          end else begin
            sel_d       = winner;
            sel_valid_d = 1'b0;
            clr_d       = 1'b1;
            state_d     = SWITCH;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        sel_valid_d = 1'b0;
      end
    endcase
    idle_d = (state_d == IDLE);
  end

  // State and output registers; reset takes effect immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel       <= '0;
      sel_valid <= 1'b0;
      clr       <= 1'b0;
      idle      <= 1'b1;
      hold_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      sel       <= sel_d;
      sel_valid <= sel_valid_d;
      clr       <= clr_d;
      idle      <= idle_d;
      hold_cnt  <= hold_d;
    end
  end

endmodule

// File: tb/tb_ctrl_sel_fsm.sv
// ---------------------------------------------------------------------------
// tb_ctrl_sel_fsm
// Bench for ctrl_sel_fsm with three configurations driven side by side:
//   dut0: N=4, HOLD=4, fixed priority
//   dut1: N=4, HOLD=4, round-robin
//   dut2: N=5, HOLD=2, round-robin (non-power-of-2 channel count)
// A reference model describes each controller as "current owner, how many
// valid cycles it has had, whether a switch is pending" and pushes the
// expected outputs into a queue at every clock edge; a monitor pops and
// compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_ctrl_sel_fsm;

  typedef struct {
    int sel;
    bit sv;
    bit clr;
    bit idle;
  } snap_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req0, req1;
  logic [4:0] req2;
  logic [1:0] sel0, sel1;
  logic [2:0] sel2;
  logic       sv0, sv1, sv2;
  logic       clr0, clr1, clr2;
  logic       idle0, idle1, idle2;

  int n_p[3]    = '{4, 4, 5};
  int hold_p[3] = '{4, 4, 2};
  int mode_p[3] = '{0, 1, 1};

  int check_count = 0;
  int pass_count  = 0;

  snap_t exp_q[$];

  int cur[3];
  bit granted[3];
  bit pending[3];
  int age[3];

  ctrl_sel_fsm #(.N(4), .HOLD(4), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .sel(sel0),
    .sel_valid(sv0), .clr(clr0), .idle(idle0)
  );

  ctrl_sel_fsm #(.N(4), .HOLD(4), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .sel(sel1),
    .sel_valid(sv1), .clr(clr1), .idle(idle1)
  );

  ctrl_sel_fsm #(.N(5), .HOLD(2), .MODE(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .sel(sel2),
    .sel_valid(sv2), .clr(clr2), .idle(idle2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records one comparison and reports it when it does not hold.
  task automatic checkOutput(input string name, input int actual, input int expected);
    check_count++;
    if (actual == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Drives all three request vectors and waits the given number of cycles.
  task automatic applyStimulus(input logic [3:0] r0, input logic [3:0] r1,
                               input logic [4:0] r2, input int cycles);
    req0 = r0;
    req1 = r1;
    req2 = r2;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic applyReset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic waitValid0(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (sv0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic int reqOf(input int i);
    if (i == 0) return int'(req0);
    if (i == 1) return int'(req1);
    return int'(req2);
  endfunction

  // Winner rule: fixed priority takes the lowest set index; round-robin
  // takes the first set index after base, wrapping around. -1 means none.
  function automatic int pickRef(input int r, input int base, input int n, input int mode);
    int idx;
    for (int k = 0; k < n; k++) begin
      idx = (mode == 0) ? k : (base + 1 + k) % n;
      if (((r >> idx) & 1) == 1) return idx;
    end
    return -1;
  endfunction

  // Reference model, advanced once per rising edge.
  always @(posedge clk) begin : model
    int c, a, w, r;
    bit g, p;
    for (int i = 0; i < 3; i++) begin
      c = cur[i];
      g = granted[i];
      p = pending[i];
      a = age[i];
      r = reqOf(i);
      if (!rst_n) begin
        c = 0; g = 1'b0; p = 1'b0; a = 0;
      end else if (p) begin
        p = 1'b0; g = 1'b1; a = 1;
      end else if (g) begin
        if (((r >> c) & 1) == 0 || a >= hold_p[i]) begin
          w = pickRef(r, c, n_p[i], mode_p[i]);
          if (w < 0) g = 1'b0;
          else if (w == c) a = 1;
          else begin c = w; g = 1'b0; p = 1'b1; end
        end else begin
          a = a + 1;
        end
      end else begin
        w = pickRef(r, c, n_p[i], mode_p[i]);
        if (w >= 0) begin c = w; p = 1'b1; end
      end
      cur[i]     <= c;
      granted[i] <= g;
      pending[i] <= p;
      age[i]     <= a;
      exp_q.push_back('{sel: c, sv: g, clr: p, idle: (!g && !p)});
    end
  end

  // A reset mid-cycle discards whatever the last edge predicted.
  always @(negedge rst_n) exp_q.delete();

  // Monitor: compares every presented output set against the model.
  always @(negedge clk) begin : monitor
    snap_t s;
    int a_sel;
    int a_sv, a_clr, a_idle;
    if (exp_q.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        s = exp_q.pop_front();
        a_sel  = (i == 0) ? int'(sel0)  : (i == 1) ? int'(sel1)  : int'(sel2);
        a_sv   = (i == 0) ? int'(sv0)   : (i == 1) ? int'(sv1)   : int'(sv2);
        a_clr  = (i == 0) ? int'(clr0)  : (i == 1) ? int'(clr1)  : int'(clr2);
        a_idle = (i == 0) ? int'(idle0) : (i == 1) ? int'(idle1) : int'(idle2);
        checkOutput($sformatf("dut%0d.sel", i), a_sel, s.sel);
        checkOutput($sformatf("dut%0d.sel_valid", i), a_sv, int'(s.sv));
        checkOutput($sformatf("dut%0d.clr", i), a_clr, int'(s.clr));
        checkOutput($sformatf("dut%0d.idle", i), a_idle, int'(s.idle));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    bit ok;
    bit saw_clr;
    int exp_low;
    int got;
    int rr_sel[5];
    int rr_exp[5] = '{0, 1, 2, 3, 0};
    bit prev_sv;

    rst_n = 1'b0;
    req0 = '0; req1 = '0; req2 = '0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] single request held on fixed-priority instance");
    applyStimulus(4'b0001, 4'b0000, 5'b00000, 15);
    applyStimulus(4'b0000, 4'b0000, 5'b00000, 3);

    $display("[TB] lower-priority request arriving during a grant");
    applyStimulus(4'b1010, 4'b0000, 5'b00000, 3);
    checkOutput("t3_first_sel", int'(sel0), 1);
    checkOutput("t3_first_valid", int'(sv0), 1);
    applyStimulus(4'b1011, 4'b0000, 5'b00000, 10);
    checkOutput("t3_final_sel", int'(sel0), 0);
    checkOutput("t3_final_valid", int'(sv0), 1);
    applyStimulus(4'b0000, 4'b0000, 5'b00000, 3);

    $display("[TB] early release at hold count 1");
    req0 = 4'b0100;
    waitValid0(ok);
    checkOutput("t5_wait_valid", int'(ok), 1);
    @(negedge clk);
    req0 = 4'b0000;
    @(negedge clk);
    checkOutput("t5_idle", int'(idle0), 1);
    checkOutput("t5_valid", int'(sv0), 0);
    checkOutput("t5_sel_held", int'(sel0), 2);

    $display("[TB] asynchronous reset in the middle of a grant");
    req0 = 4'b0100;
    waitValid0(ok);
    checkOutput("t1_wait_valid", int'(ok), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t1_sel", int'(sel0), 0);
    checkOutput("t1_valid", int'(sv0), 0);
    checkOutput("t1_clr", int'(clr0), 0);
    checkOutput("t1_idle", int'(idle0), 1);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 5'b00000, 3);

    $display("[TB] round-robin rotation over all channels");
    applyStimulus(4'b0000, 4'b1000, 5'b00000, 6);
    applyStimulus(4'b0000, 4'b0000, 5'b00000, 3);
    req1    = 4'b1111;
    got     = 0;
    prev_sv = sv1;
    for (int k = 0; k < 60 && got < 5; k++) begin
      @(negedge clk);
      if (sv1 && !prev_sv) begin
        rr_sel[got] = int'(sel1);
        got++;
      end
      prev_sv = sv1;
    end
    checkOutput("t4_grant_count", got, 5);
    for (int k = 0; k < got; k++)
      checkOutput($sformatf("t4_grant%0d_sel", k), rr_sel[k], rr_exp[k]);
    applyStimulus(4'b0000, 4'b0000, 5'b00000, 3);

    $display("[TB] fixed-priority sweep of all request patterns");
    for (int r = 0; r < 16; r++) begin
      applyReset();
      saw_clr = 1'b0;
      exp_low = -1;
      for (int b = 3; b >= 0; b--) if (r[b]) exp_low = b;
      req0 = 4'(r);
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (clr0) saw_clr = 1'b1;
      end
      if (r == 0) begin
        checkOutput("t6_idle_r0", int'(idle0), 1);
        checkOutput("t6_noclr_r0", int'(saw_clr), 0);
      end else begin
        checkOutput($sformatf("t6_sel_r%0d", r), int'(sel0), exp_low);
        checkOutput($sformatf("t6_valid_r%0d", r), int'(sv0), 1);
      end
      req0 = 4'b0000;
    end
    applyStimulus(4'b0000, 4'b0000, 5'b00000, 3);

    $display("[TB] randomized requests on all instances");
    for (int c = 0; c < 400; c++) begin
      if (c == 200) applyReset();
      if ($urandom_range(3) == 0) begin
        req0 = 4'($urandom);
        req1 = 4'($urandom);
        req2 = 5'($urandom);
      end
      @(negedge clk);
    end

    applyStimulus(4'b0000, 4'b0000, 5'b00000, 4);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
